// File: rtl/cpu_exec_sequencer_if.sv
// Command and core-control bundle between the register side, the execution
// sequencer and the CPU core.
//
// Handshake: CMD_OP/CMD_STEPS are held stable while CMD_VALID is high; a
// command transfers on the CCLK edge where CMD_VALID && CMD_READY. CMD_READY
// is combinational and does not depend on CMD_VALID.
interface cpu_exec_sequencer_if #(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [STEP_W-1:0] CMD_STEPS;
  logic              BP_EN;
  logic [31:0]       BP_ADDR;
  logic [31:0]       REGPC;
  logic              CRST;
  logic              CEXEC;
  logic [1:0]        STATE;
  logic [1:0]        HALT_CAUSE;
  logic [CNT_W-1:0]  EXEC_CNT;
  logic              DONE_PULSE;

  // Register side / core model view.
  modport master (
    output CMD_VALID, CMD_OP, CMD_STEPS, BP_EN, BP_ADDR, REGPC,
    input  CMD_READY, CRST, CEXEC, STATE, HALT_CAUSE, EXEC_CNT, DONE_PULSE
  );

  // Sequencer view.
  modport slave (
    input  CMD_VALID, CMD_OP, CMD_STEPS, BP_EN, BP_ADDR, REGPC,
    output CMD_READY, CRST, CEXEC, STATE, HALT_CAUSE, EXEC_CNT, DONE_PULSE
  );
endinterface

// File: rtl/cpu_exec_sequencer.sv
// CPU execution sequencer: runs, single/multi-steps, halts and resets the
// core in the CCLK domain. Halts on a PC breakpoint (checked before the
// instruction at BP_ADDR executes) or when the step budget is used up.
module cpu_exec_sequencer #(
  parameter int STEP_W     = 16,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4
) (
  input logic                  CCLK,
  input logic                  CARSTN,
  cpu_exec_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RESET = 2'b01,
    ST_RUN   = 2'b10,
    ST_STEP  = 2'b11
  } state_t;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HALT = 2'b01;
  localparam logic [1:0] CAUSE_STEP = 2'b10;
  localparam logic [1:0] CAUSE_BP   = 2'b11;

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              first_q, first_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  exec_cnt_q;
  logic              crst_q;
  logic              done_q;

  logic cmd_ready;
  logic cmd_fire;
  logic bp_hit;
  logic exec_en;
  logic is_halt;
  logic is_reset;

  // Handshake and breakpoint decode. The first cycle after entering RUN/STEP
  // ignores the breakpoint so execution can resume from a breakpoint PC.
  always_comb begin
    cmd_ready = (state_q != ST_RESET);
    cmd_fire  = bus.CMD_VALID && cmd_ready;
    is_halt   = cmd_fire && (bus.CMD_OP == OP_HALT);
    is_reset  = cmd_fire && (bus.CMD_OP == OP_RESET);
    bp_hit    = bus.BP_EN && (bus.REGPC == bus.BP_ADDR) && !first_q;
    exec_en   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_hit;
  end

  // Next-state logic. Breakpoint beats HALT/RESET, which beat step-done.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    first_d    = first_q;
    cause_d    = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (bus.CMD_OP)
            OP_RUN: begin
              state_d = ST_RUN;
              cause_d = CAUSE_NONE;
              first_d = 1'b1;
            end
            OP_STEP: begin
              state_d    = ST_STEP;
              cause_d    = CAUSE_NONE;
              first_d    = 1'b1;
              step_cnt_d = (bus.CMD_STEPS == '0) ? STEP_W'(1) : bus.CMD_STEPS;
            end
            OP_RESET: begin
              state_d   = ST_RESET;
              rst_cnt_d = RST_LAST;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        first_d = 1'b0;
        if (bp_hit) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_BP;
        end else if (is_halt) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_HALT;
        end else if (is_reset) begin
          state_d   = ST_RESET;
          rst_cnt_d = RST_LAST;
        end
      end
      ST_STEP: begin
        first_d = 1'b0;
        if (exec_en) step_cnt_d = step_cnt_q - STEP_W'(1);
        if (bp_hit) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_BP;
        end else if (is_halt) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_HALT;
        end else if (is_reset) begin
          state_d   = ST_RESET;
          rst_cnt_d = RST_LAST;
        end else if (exec_en && (step_cnt_q == STEP_W'(1))) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_STEP;
        end
      end
      ST_RESET: begin
        cause_d = CAUSE_NONE;
        if (rst_cnt_q == '0) state_d = ST_IDLE;
        else                 rst_cnt_d = rst_cnt_q - RST_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus registered CRST and return-to-idle pulse.
  always_ff @(posedge CCLK or negedge CARSTN) begin
    if (!CARSTN) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      rst_cnt_q  <= '0;
      first_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      crst_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      first_q    <= first_d;
      cause_q    <= cause_d;
      crst_q     <= (state_d == ST_RESET);
      done_q     <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end
  end

  // Executed-cycle counter: cleared during RESET, saturates at all-ones.
  always_ff @(posedge CCLK or negedge CARSTN) begin
    if (!CARSTN) begin
      exec_cnt_q <= '0;
    end else if (state_q == ST_RESET) begin
      exec_cnt_q <= '0;
    end else if (exec_en && !(&exec_cnt_q)) begin
      exec_cnt_q <= exec_cnt_q + CNT_W'(1);
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.CEXEC      = exec_en;
  assign bus.CRST       = crst_q;
  assign bus.STATE      = state_q;
  assign bus.HALT_CAUSE = cause_q;
  assign bus.EXEC_CNT   = exec_cnt_q;
  assign bus.DONE_PULSE = done_q;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Bench for cpu_exec_sequencer. The bench plays the core (REGPC advances by
// 4 after every CEXEC cycle) and predicts each command's outcome with an
// instruction-level model of run/step/breakpoint/halt behaviour.
module tb_cpu_exec_sequencer;
  localparam int STEP_W     = 16;
  localparam int CNT_W      = 8;
  localparam int RST_CYCLES = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  localparam logic [1:0] OP_HALT = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_RESET = 2'b11;
  localparam logic [1:0] C_NONE = 2'b00, C_HALT = 2'b01, C_STEP = 2'b10, C_BP = 2'b11;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b10;

  // ---------------- clock / reset ----------------
  logic CCLK = 1'b0;
  logic CARSTN;
  always #5 CCLK = ~CCLK;

  cpu_exec_sequencer_if #(.STEP_W(STEP_W), .CNT_W(CNT_W)) bus ();

  cpu_exec_sequencer #(.STEP_W(STEP_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) dut (
    .CCLK   (CCLK),
    .CARSTN (CARSTN),
    .bus    (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int exp_exec = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc = 32'h0;

  logic [1:0]       s_state, s_cause;
  logic             s_cexec, s_crst, s_ready, s_done;
  logic [CNT_W-1:0] s_exec;
  int obs_cexec, obs_done, obs_crst, obs_nrdy;

  // Instruction-level model: walk instructions from p0; a breakpoint stops
  // before executing (never on the very first), HALT presented in cycle
  // halt_at still executes that cycle, a step ends after max(n,1) executions.
  function automatic void predict(input logic [31:0] p0, input bit bpe, input logic [31:0] b,
                                  input bit is_step, input int n, input int halt_at,
                                  output int cyc, output logic [1:0] cause);
    logic [31:0] p = p0;
    int nn = (n == 0) ? 1 : n;
    cyc = 0;
    cause = C_NONE;
    for (int c = 0; c < 10000; c++) begin
      if (c > 0 && bpe && p == b) begin cause = C_BP; break; end
      cyc++;
      p = p + 32'd4;
      if (c == halt_at) begin cause = C_HALT; break; end
      if (is_step && cyc == nn) begin cause = C_STEP; break; end
    end
  endfunction

  function automatic void add_exec(input int n);
    exp_exec = (exp_exec + n > CNT_MAX) ? CNT_MAX : exp_exec + n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_cexec = 0; obs_done = 0; obs_crst = 0; obs_nrdy = 0;
  endtask

  // Sample one cycle at the falling edge, then let the core model advance.
  task automatic tick();
    @(negedge CCLK);
    s_state = bus.STATE;  s_cause = bus.HALT_CAUSE; s_exec = bus.EXEC_CNT;
    s_cexec = bus.CEXEC;  s_crst = bus.CRST; s_ready = bus.CMD_READY; s_done = bus.DONE_PULSE;
    if (s_cexec) obs_cexec++;
    if (s_done) obs_done++;
    if (s_crst) obs_crst++;
    if (!s_ready) obs_nrdy++;
    @(posedge CCLK);
    #1;
    if (s_cexec) pc = pc + 32'd4;
    bus.REGPC = pc;
  endtask

  task automatic issue(input logic [1:0] op, input logic [STEP_W-1:0] steps);
    bus.CMD_VALID = 1'b1; bus.CMD_OP = op; bus.CMD_STEPS = steps;
    tick();
    bus.CMD_VALID = 1'b0; bus.CMD_OP = OP_HALT; bus.CMD_STEPS = '0;
  endtask

  // Issue op, optionally present HALT in cycle halt_at, run until IDLE seen.
  task automatic run_op(input logic [1:0] op, input int steps, input int halt_at,
                        input int budget, output bit ok);
    ok = 1'b0;
    clear_obs();
    issue(op, steps[STEP_W-1:0]);
    for (int c = 0; c < budget; c++) begin
      if (c == halt_at) begin bus.CMD_VALID = 1'b1; bus.CMD_OP = OP_HALT; end
      tick();
      bus.CMD_VALID = 1'b0; bus.CMD_OP = OP_HALT;
      if (s_state == S_IDLE) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    CARSTN = 1'b0;
    bus.CMD_VALID = 1'b0; bus.CMD_OP = OP_HALT; bus.CMD_STEPS = '0;
    bus.BP_EN = 1'b0; bus.BP_ADDR = 32'h0; pc = 32'h0; bus.REGPC = pc;
    repeat (3) @(posedge CCLK);
    #1;
    n_vec++; if (bus.STATE !== S_IDLE) begin n_err++; $display("FAIL rst_state: got %0d expected 0", bus.STATE); end
    n_vec++; if (bus.CRST !== 1'b0) begin n_err++; $display("FAIL rst_crst: got %0b expected 0", bus.CRST); end
    n_vec++; if (bus.CEXEC !== 1'b0) begin n_err++; $display("FAIL rst_cexec: got %0b expected 0", bus.CEXEC); end
    n_vec++; if (bus.HALT_CAUSE !== C_NONE) begin n_err++; $display("FAIL rst_cause: got %0d expected 0", bus.HALT_CAUSE); end
    n_vec++; if (bus.EXEC_CNT !== '0) begin n_err++; $display("FAIL rst_exec: got %0d expected 0", bus.EXEC_CNT); end
    n_vec++; if (bus.DONE_PULSE !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b expected 0", bus.DONE_PULSE); end
    CARSTN = 1'b1;
    clear_obs();
    tick();
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b expected 1", s_ready); end
    n_vec++; if (s_state !== S_IDLE || s_cexec !== 1'b0) begin n_err++; $display("FAIL rst_idle: got state %0d cexec %0b expected 0/0", s_state, s_cexec); end
    exp_exec = 0;
  endtask

  task automatic test_step();
    bit ok;
    run_op(OP_STEP, 3, -1, 50, ok);
    add_exec(3);
    n_vec++; if (!ok) begin n_err++; $display("FAIL step3_timeout: got busy expected idle"); end
    n_vec++; if (obs_cexec != 3) begin n_err++; $display("FAIL step3_cexec: got %0d expected 3", obs_cexec); end
    n_vec++; if (s_cause !== C_STEP) begin n_err++; $display("FAIL step3_cause: got %0d expected 2", s_cause); end
    n_vec++; if (s_exec !== CNT_W'(exp_exec)) begin n_err++; $display("FAIL step3_exec: got %0d expected %0d", s_exec, exp_exec); end
    tick();
    n_vec++; if (obs_done != 1 || s_done !== 1'b0) begin n_err++; $display("FAIL step3_done: got %0d pulses expected 1", obs_done); end
    run_op(OP_STEP, 0, -1, 50, ok);
    add_exec(1);
    n_vec++; if (!ok || obs_cexec != 1) begin n_err++; $display("FAIL step0_cexec: got %0d expected 1", obs_cexec); end
    n_vec++; if (s_cause !== C_STEP) begin n_err++; $display("FAIL step0_cause: got %0d expected 2", s_cause); end
    tick();
  endtask

  task automatic test_breakpoint();
    bit ok;
    pc = 32'h0; bus.REGPC = pc; bus.BP_EN = 1'b1; bus.BP_ADDR = 32'h10;
    run_op(OP_RUN, 0, -1, 50, ok);
    add_exec(4);
    n_vec++; if (!ok || obs_cexec != 4) begin n_err++; $display("FAIL bp_cexec: got %0d expected 4", obs_cexec); end
    n_vec++; if (s_cause !== C_BP) begin n_err++; $display("FAIL bp_cause: got %0d expected 3", s_cause); end
    n_vec++; if (s_exec !== CNT_W'(exp_exec)) begin n_err++; $display("FAIL bp_exec: got %0d expected %0d", s_exec, exp_exec); end
    n_vec++; if (pc !== 32'h10) begin n_err++; $display("FAIL bp_pc: got %0h expected 10", pc); end
    tick();
    // Resume from the breakpoint PC; halt after a few cycles.
    run_op(OP_RUN, 0, 5, 50, ok);
    add_exec(6);
    n_vec++; if (!ok || obs_cexec != 6) begin n_err++; $display("FAIL bp_resume_cexec: got %0d expected 6", obs_cexec); end
    n_vec++; if (s_cause !== C_HALT) begin n_err++; $display("FAIL bp_resume_cause: got %0d expected 1", s_cause); end
    tick();
    bus.BP_EN = 1'b0;
  endtask

  task automatic test_reset_cmd();
    bit ok = 1'b0;
    clear_obs();
    issue(OP_RESET, '0);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s_state == S_IDLE) begin ok = 1'b1; break; end
    end
    exp_exec = 0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL rcmd_timeout: got busy expected idle"); end
    n_vec++; if (obs_crst != RST_CYCLES) begin n_err++; $display("FAIL rcmd_crst: got %0d expected %0d", obs_crst, RST_CYCLES); end
    n_vec++; if (obs_nrdy != RST_CYCLES) begin n_err++; $display("FAIL rcmd_ready: got %0d not-ready expected %0d", obs_nrdy, RST_CYCLES); end
    n_vec++; if (s_exec !== '0 || s_cause !== C_NONE) begin n_err++; $display("FAIL rcmd_clear: got exec %0d cause %0d expected 0/0", s_exec, s_cause); end
    n_vec++; if (obs_done != 1 || s_done !== 1'b1) begin n_err++; $display("FAIL rcmd_done: got %0d expected 1", obs_done); end
    tick();
  endtask

  task automatic test_run_halt();
    bit ok = 1'b0;
    run_op(OP_RUN, 0, 6, 50, ok);
    add_exec(7);
    n_vec++; if (!ok || obs_cexec != 7) begin n_err++; $display("FAIL halt_cexec: got %0d expected 7", obs_cexec); end
    n_vec++; if (s_exec !== CNT_W'(7)) begin n_err++; $display("FAIL halt_exec: got %0d expected 7", s_exec); end
    n_vec++; if (s_cause !== C_HALT) begin n_err++; $display("FAIL halt_cause: got %0d expected 1", s_cause); end
    tick();
    // A RUN while running is dropped.
    clear_obs();
    issue(OP_RUN, '0);
    tick(); tick();
    issue(OP_RUN, '0);
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready: got %0b expected 1", s_ready); end
    tick();
    n_vec++; if (s_state !== S_RUN) begin n_err++; $display("FAIL drop_state: got %0d expected 2", s_state); end
    issue(OP_HALT, '0);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_state == S_IDLE) begin ok = 1'b1; break; end
    end
    add_exec(5);
    n_vec++; if (!ok || obs_cexec != 5 || s_cause !== C_HALT) begin n_err++; $display("FAIL drop_halt: got %0d cycles cause %0d expected 5 cause 1", obs_cexec, s_cause); end
    n_vec++; if (s_exec !== CNT_W'(exp_exec)) begin n_err++; $display("FAIL drop_exec: got %0d expected %0d", s_exec, exp_exec); end
    tick();
  endtask

  task automatic test_random();
    bit ok;
    bit bpe, is_step;
    int n, halt_at, cyc;
    logic [31:0] b, want;
    logic [1:0] cause;
    for (int it = 0; it < 24; it++) begin
      pc = {$urandom_range(0, 1023), 2'b00};
      bus.REGPC = pc;
      bpe = 1'($urandom_range(0, 1));
      b = pc + 32'($urandom_range(0, 15)) * 32'd4;
      bus.BP_EN = bpe; bus.BP_ADDR = b;
      is_step = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 12);
      halt_at = is_step ? -1 : $urandom_range(0, 20);
      predict(pc, bpe, b, is_step, n, halt_at, cyc, cause);
      exp_q.push_back(32'(cyc));
      run_op(is_step ? OP_STEP : OP_RUN, n, halt_at, 100, ok);
      add_exec(cyc);
      want = exp_q.pop_front();
      n_vec++; if (!ok || obs_cexec != int'(want)) begin n_err++; $display("FAIL rand%0d_cexec: got %0d expected %0d", it, obs_cexec, want); end
      n_vec++; if (s_cause !== cause) begin n_err++; $display("FAIL rand%0d_cause: got %0d expected %0d", it, s_cause, cause); end
      n_vec++; if (s_exec !== CNT_W'(exp_exec)) begin n_err++; $display("FAIL rand%0d_exec: got %0d expected %0d", it, s_exec, exp_exec); end
      tick();
      n_vec++; if (obs_done != 1) begin n_err++; $display("FAIL rand%0d_done: got %0d expected 1", it, obs_done); end
    end
    bus.BP_EN = 1'b0;
  endtask

  task automatic test_saturation();
    bit ok;
    issue(OP_RESET, '0);
    repeat (RST_CYCLES + 2) tick();
    exp_exec = 0;
    run_op(OP_RUN, 0, 299, 400, ok);
    add_exec(300);
    n_vec++; if (!ok || obs_cexec != 300) begin n_err++; $display("FAIL sat_cexec: got %0d expected 300", obs_cexec); end
    n_vec++; if (s_exec !== CNT_W'(CNT_MAX)) begin n_err++; $display("FAIL sat_exec: got %0d expected %0d", s_exec, CNT_MAX); end
    tick();
  endtask

  task automatic test_async_reset();
    clear_obs();
    issue(OP_STEP, 16'd100);
    repeat (5) tick();
    #2;
    CARSTN = 1'b0;
    #1;
    exp_exec = 0;
    n_vec++; if (bus.CEXEC !== 1'b0) begin n_err++; $display("FAIL arst_cexec: got %0b expected 0", bus.CEXEC); end
    n_vec++; if (bus.STATE !== S_IDLE) begin n_err++; $display("FAIL arst_state: got %0d expected 0", bus.STATE); end
    n_vec++; if (bus.EXEC_CNT !== '0) begin n_err++; $display("FAIL arst_exec: got %0d expected 0", bus.EXEC_CNT); end
    @(posedge CCLK);
    #1;
    CARSTN = 1'b1;
    clear_obs();
    repeat (10) tick();
    n_vec++; if (obs_cexec != 0 || obs_done != 0) begin n_err++; $display("FAIL arst_quiet: got %0d cexec %0d done expected 0/0", obs_cexec, obs_done); end
    n_vec++; if (s_state !== S_IDLE || s_exec !== '0) begin n_err++; $display("FAIL arst_idle: got state %0d exec %0d expected 0/0", s_state, s_exec); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_reset_cmd();
    test_run_halt();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
